// File: rtl/bk_mouse_pkg.sv
// Shared definitions for the BK mouse port: state-word bit indices, sequencer states
// and default accumulator/threshold tuning.
package bk_mouse_pkg;

  localparam int MS_UP    = 0;
  localparam int MS_RIGHT = 1;
  localparam int MS_DOWN  = 2;
  localparam int MS_LEFT  = 3;
  localparam int MS_ZERO  = 4;
  localparam int MS_LBTN  = 5;
  localparam int MS_RBTN  = 6;

  localparam int ACC_W_DEF      = 12;
  localparam int THRESH_POS_DEF = 4;
  localparam int THRESH_NEG_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2
  } fsm_t;

endpackage

// File: rtl/bk_mouse_axis.sv
// One mouse axis: saturating signed accumulator, threshold evaluation and sticky
// positive/negative direction flags. Optional delta doubling under BK_MOUSE_ACCEL_EN.
module bk_mouse_axis
  import bk_mouse_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int THRESH_POS = THRESH_POS_DEF,
  parameter int THRESH_NEG = THRESH_NEG_DEF
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [8:0] delta_i,
  input  logic       accum_en_i,
  input  logic       eval_en_i,
  input  logic       clear_i,
  output logic       pos_o,
  output logic       neg_o
);

  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0]    SAT_MAX = SW'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0]    SAT_MIN = -SAT_MAX;
  localparam logic signed [ACC_W-1:0] T_POS   = ACC_W'(THRESH_POS);
  localparam logic signed [ACC_W-1:0] T_NEG   = ACC_W'(THRESH_NEG);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    pos_q, pos_d;
  logic                    neg_q, neg_d;
  logic signed [9:0]       d_eff;
  logic signed [SW-1:0]    sum;

  always_comb begin
    d_eff = {delta_i[8], delta_i};
`ifdef BK_MOUSE_ACCEL_EN
    if ($signed(delta_i) > 9'sd8 || $signed(delta_i) < -9'sd8)
      d_eff = {delta_i, 1'b0};
`endif
    // One guard bit so the sum can exceed the clamp range before saturation
    sum   = SW'(acc_q) + SW'(d_eff);
    acc_d = acc_q;
    pos_d = pos_q;
    neg_d = neg_q;
    if (clear_i) begin
      acc_d = '0;
      pos_d = 1'b0;
      neg_d = 1'b0;
    end else if (accum_en_i) begin
      if (sum > SAT_MAX)      acc_d = SAT_MAX[ACC_W-1:0];
      else if (sum < SAT_MIN) acc_d = SAT_MIN[ACC_W-1:0];
      else                    acc_d = sum[ACC_W-1:0];
    end else if (eval_en_i && !pos_q && !neg_q) begin
      if (acc_q >= T_POS) begin
        pos_d = 1'b1;
        acc_d = acc_q - T_POS;
      end else if (acc_q <= -T_NEG) begin
        neg_d = 1'b1;
        acc_d = acc_q + T_NEG;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

  assign pos_o = pos_q;
  assign neg_o = neg_q;

endmodule

// File: rtl/bk_mouse_port.sv
// BK parallel-port (0177714) mouse/joystick read source. PS/2 deltas are accumulated per axis
// into sticky direction bits; optional delta acceleration via BK_MOUSE_ACCEL_EN.
module bk_mouse_port
  import bk_mouse_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int THRESH_POS = THRESH_POS_DEF,
  parameter int THRESH_NEG = THRESH_NEG_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mouse_data_ready,
  input  logic [8:0]  pointer_dx,
  input  logic [8:0]  pointer_dy,
  input  logic        left_btn,
  input  logic        right_btn,
  input  logic [7:0]  joystick,
  input  logic        port_sel,
  input  logic        port_write,
  input  logic [1:0]  bus_wtbt,
  input  logic [15:0] bus_din,
  output logic [15:0] port_data
);

  fsm_t       fsm_q, fsm_d;
  logic       enable_q, enable_d;
  logic       wr_prev_q;
  logic       use_mouse_q, use_mouse_d;
  logic [1:0] btn_q;
  logic [8:0] dx_q, dx_d, dy_q, dy_d;
  logic       wr_edge, pkt_take;
  logic       accum_en, eval_en, axis_clear;
  logic       x_pos, x_neg, y_pos, y_neg;
  logic [6:0] state;
  logic       unused_bits;

  assign unused_bits = ^{bus_din[15:4], bus_din[2:0], bus_wtbt[1]};

  // A write edge pre-empts any packet activity in the same cycle
  assign wr_edge    = port_write & bus_wtbt[0] & ~wr_prev_q;
  assign pkt_take   = (fsm_q == IDLE) & mouse_data_ready & enable_q & ~wr_edge;
  assign accum_en   = (fsm_q == ACCUM) & ~wr_edge;
  assign eval_en    = (fsm_q == EVAL) & ~wr_edge;
  assign axis_clear = wr_edge & ~bus_din[3];

  always_comb begin
    fsm_d       = fsm_q;
    enable_d    = enable_q;
    use_mouse_d = use_mouse_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    if (wr_edge) begin
      fsm_d    = IDLE;
      enable_d = bus_din[3];
    end else begin
      case (fsm_q)
        IDLE:    if (pkt_take) fsm_d = ACCUM;
        ACCUM:   fsm_d = EVAL;
        EVAL:    fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
    if (pkt_take) begin
      dx_d = pointer_dx;
      dy_d = pointer_dy;
    end
    if (mouse_data_ready)  use_mouse_d = 1'b1;
    else if (|joystick)    use_mouse_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fsm_q       <= IDLE;
      enable_q    <= 1'b0;
      wr_prev_q   <= 1'b0;
      use_mouse_q <= 1'b0;
      btn_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
    end else begin
      fsm_q       <= fsm_d;
      enable_q    <= enable_d;
      wr_prev_q   <= port_write & bus_wtbt[0];
      use_mouse_q <= use_mouse_d;
      btn_q       <= {right_btn, left_btn};
      dx_q        <= dx_d;
      dy_q        <= dy_d;
    end
  end

  bk_mouse_axis #(
    .ACC_W      (ACC_W),
    .THRESH_POS (THRESH_POS),
    .THRESH_NEG (THRESH_NEG)
  ) u_axis_x (
    .clk_i      (clk_sys),
    .reset_i    (reset),
    .delta_i    (dx_q),
    .accum_en_i (accum_en),
    .eval_en_i  (eval_en),
    .clear_i    (axis_clear),
    .pos_o      (x_pos),
    .neg_o      (x_neg)
  );

  bk_mouse_axis #(
    .ACC_W      (ACC_W),
    .THRESH_POS (THRESH_POS),
    .THRESH_NEG (THRESH_NEG)
  ) u_axis_y (
    .clk_i      (clk_sys),
    .reset_i    (reset),
    .delta_i    (dy_q),
    .accum_en_i (accum_en),
    .eval_en_i  (eval_en),
    .clear_i    (axis_clear),
    .pos_o      (y_pos),
    .neg_o      (y_neg)
  );

  always_comb begin
    state          = '0;
    state[MS_UP]    = y_pos;
    state[MS_RIGHT] = x_pos;
    state[MS_DOWN]  = y_neg;
    state[MS_LEFT]  = x_neg;
    state[MS_LBTN]  = btn_q[0];
    state[MS_RBTN]  = btn_q[1];
    port_data = '0;
    if (port_sel) port_data = use_mouse_q ? {9'd0, state} : {8'd0, joystick};
  end

endmodule
